// File: rtl/conv_pkg.sv
// Shared constants and window indexing for the 5x5 convolution path.
package conv_pkg;

  localparam int unsigned DATA_WIDTH  = 16;
  localparam int unsigned KERNEL_SIZE = 5;
  localparam int unsigned FRAC_BIT    = 8;

  // Flat window element index; the weight loader uses the same ordering.
  function automatic int unsigned win_idx(input int unsigned r, input int unsigned c,
                                          input int unsigned k = KERNEL_SIZE);
    return r * k + c;
  endfunction

endpackage

// File: rtl/conv_window_buffer_if.sv
// Pixel-in / window-out handshake bundle for conv_window_buffer.
interface conv_window_buffer_if #(
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned KERNEL_SIZE = 5
);
  logic [DATA_WIDTH-1:0]                         pixel_in;
  logic                                          pixel_valid;
  logic                                          pixel_ready;
  logic                                          out_ready;
  logic                                          window_valid;
  logic [KERNEL_SIZE*KERNEL_SIZE*DATA_WIDTH-1:0] pixel_data;
  logic                                          frame_done;

  modport master (
    output pixel_in, pixel_valid, out_ready,
    input  pixel_ready, window_valid, pixel_data, frame_done
  );

  modport slave (
    input  pixel_in, pixel_valid, out_ready,
    output pixel_ready, window_valid, pixel_data, frame_done
  );
endinterface

// File: rtl/conv_line_buffer.sv
// One image-row delay: combinational read of the old word, write on the same address.
module conv_line_buffer #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned DEPTH      = 28
) (
  input  logic                     clk,
  input  logic                     en,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [DATA_WIDTH-1:0]    din,
  output logic [DATA_WIDTH-1:0]    dout
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  assign dout = mem[addr];

  always_ff @(posedge clk) begin
    if (en) mem[addr] <= din;
  end

endmodule

// File: rtl/conv_window_buffer.sv
// Raster pixel stream to KERNEL_SIZE x KERNEL_SIZE sliding window (stride 1, no padding).
module conv_window_buffer
  import conv_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = conv_pkg::DATA_WIDTH,
  parameter int unsigned KERNEL_SIZE = conv_pkg::KERNEL_SIZE,
  parameter int unsigned IMG_WIDTH   = 28,
  parameter int unsigned IMG_HEIGHT  = 28
) (
  input logic                 clk,
  input logic                 reset,
  conv_window_buffer_if.slave bus
);

  localparam int unsigned COL_W = $clog2(IMG_WIDTH);
  localparam int unsigned ROW_W = $clog2(IMG_HEIGHT);
  localparam int unsigned K1    = KERNEL_SIZE - 1;
  localparam int unsigned WBITS = KERNEL_SIZE * KERNEL_SIZE * DATA_WIDTH;

  logic [COL_W-1:0]      col_cnt;
  logic [ROW_W-1:0]      row_cnt;
  logic [DATA_WIDTH-1:0] lb_in  [K1];
  logic [DATA_WIDTH-1:0] lb_out [K1];
  logic [DATA_WIDTH-1:0] win    [KERNEL_SIZE][KERNEL_SIZE];
  logic [WBITS-1:0]      data_flat;
  logic                  window_valid;
  logic                  frame_done;
  logic                  ready;
  logic                  accept;
  logic                  col_last;
  logic                  row_last;
  logic                  win_pos;

  assign ready    = !(window_valid && !bus.out_ready);
  assign accept   = bus.pixel_valid && ready;
  assign col_last = (col_cnt == COL_W'(IMG_WIDTH - 1));
  assign row_last = (row_cnt == ROW_W'(IMG_HEIGHT - 1));
  assign win_pos  = (row_cnt >= ROW_W'(K1)) && (col_cnt >= COL_W'(K1));

  // lb[0] delays the incoming row; each later buffer delays the one before it.
  for (genvar k = 0; k < K1; k++) begin : g_lb
    if (k == 0) begin : g_head
      assign lb_in[k] = bus.pixel_in;
    end else begin : g_tail
      assign lb_in[k] = lb_out[k-1];
    end
    conv_line_buffer #(
      .DATA_WIDTH(DATA_WIDTH),
      .DEPTH     (IMG_WIDTH)
    ) u_lb (
      .clk (clk),
      .en  (accept),
      .addr(col_cnt),
      .din (lb_in[k]),
      .dout(lb_out[k])
    );
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned r = 0; r < KERNEL_SIZE; r++)
        for (int unsigned c = 0; c < KERNEL_SIZE; c++)
          win[r][c] <= '0;
    end else if (accept) begin
      for (int unsigned r = 0; r < KERNEL_SIZE; r++)
        for (int unsigned c = 0; c < K1; c++)
          win[r][c] <= win[r][c+1];
      // Oldest row comes from the deepest line buffer.
      for (int unsigned r = 0; r < K1; r++)
        win[r][K1] <= lb_out[K1-1-r];
      win[K1][K1] <= bus.pixel_in;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      col_cnt      <= '0;
      row_cnt      <= '0;
      window_valid <= 1'b0;
      frame_done   <= 1'b0;
    end else begin
      frame_done <= accept && col_last && row_last;
      if (accept) begin
        if (col_last) begin
          col_cnt <= '0;
          row_cnt <= row_last ? '0 : row_cnt + 1'b1;
        end else begin
          col_cnt <= col_cnt + 1'b1;
        end
      end
      if (accept && win_pos)
        window_valid <= 1'b1;
      else if (bus.out_ready)
        window_valid <= 1'b0;
    end
  end

  always_comb begin
    data_flat = '0;
    for (int unsigned r = 0; r < KERNEL_SIZE; r++)
      for (int unsigned c = 0; c < KERNEL_SIZE; c++)
        data_flat[win_idx(r, c, KERNEL_SIZE)*DATA_WIDTH +: DATA_WIDTH] = win[r][c];
  end

  assign bus.pixel_ready  = ready;
  assign bus.window_valid = window_valid;
  assign bus.pixel_data   = data_flat;
  assign bus.frame_done   = frame_done;

endmodule

// File: tb/tb_conv_window_buffer.sv
// Directed bench for conv_window_buffer on an 8x6 image with a 5x5 kernel.
module tb_conv_window_buffer;

  localparam int W = 8;
  localparam int H = 6;
  localparam int NV = 14;

  typedef struct {
    int f;
    int r;
    int c;
    bit v;
    int idx;
    int elem;
  } vec_t;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  int   consumed;
  vec_t tbl [NV];

  conv_window_buffer_if #(.DATA_WIDTH(16), .KERNEL_SIZE(5)) bus ();

  conv_window_buffer #(
    .DATA_WIDTH (16),
    .KERNEL_SIZE(5),
    .IMG_WIDTH  (W),
    .IMG_HEIGHT (H)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] elem(input int i);
    return bus.pixel_data[i*16 +: 16];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Called at posedge+1; returns at the next posedge+1 with outputs updated.
  task automatic step(input logic [15:0] v, input logic pv, input logic ordy, output bit took);
    bus.pixel_in    = v;
    bus.pixel_valid = pv;
    bus.out_ready   = ordy;
    #1;
    took = pv && bus.pixel_ready;
    if (bus.window_valid && ordy) consumed++;
    @(posedge clk);
    #1;
  endtask

  task automatic run_frame(input int f, input int n);
    int  nvalid;
    int  ndone;
    int  r;
    int  c;
    bit  took;
    nvalid = 0;
    ndone  = 0;
    for (int i = 0; i < n; i++) begin
      r = i / W;
      c = i % W;
      step(16'(f*256 + r*16 + c), 1'b1, 1'b1, took);
      if (bus.window_valid) nvalid++;
      if (bus.frame_done) ndone++;
      for (int t = 0; t < NV; t++) begin
        if (tbl[t].f == f && tbl[t].r == r && tbl[t].c == c) begin
          chk($sformatf("valid_f%0d_%0d_%0d", f, r, c), 32'(bus.window_valid), 32'(tbl[t].v));
          if (tbl[t].idx >= 0)
            chk($sformatf("elem%0d_f%0d_%0d_%0d", tbl[t].idx, f, r, c),
                32'(elem(tbl[t].idx)), 32'(tbl[t].elem));
        end
      end
    end
    if (n == W*H) begin
      chk($sformatf("win_count_f%0d", f), 32'(nvalid), 32'd8);
      chk($sformatf("frame_done_count_f%0d", f), 32'(ndone), 32'd1);
    end
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_window_valid"}, 32'(bus.window_valid), 32'd0);
    chk({tag, "_frame_done"}, 32'(bus.frame_done), 32'd0);
    chk({tag, "_pixel_ready"}, 32'(bus.pixel_ready), 32'd1);
    chk({tag, "_pixel_data_zero"}, 32'(bus.pixel_data != '0), 32'd0);
  endtask

  initial begin
    bit took;
    checks   = 0;
    errors   = 0;
    consumed = 0;

    tbl[0]  = '{0, 3, 7, 1'b0, -1, 0};
    tbl[1]  = '{0, 4, 3, 1'b0, -1, 0};
    tbl[2]  = '{0, 4, 4, 1'b1, 0, 'h0000};
    tbl[3]  = '{0, 4, 4, 1'b1, 12, 'h0022};
    tbl[4]  = '{0, 4, 4, 1'b1, 24, 'h0044};
    tbl[5]  = '{0, 4, 7, 1'b1, 0, 'h0003};
    tbl[6]  = '{0, 5, 0, 1'b0, -1, 0};
    tbl[7]  = '{0, 5, 3, 1'b0, -1, 0};
    tbl[8]  = '{0, 5, 4, 1'b1, 0, 'h0010};
    tbl[9]  = '{0, 5, 7, 1'b1, 24, 'h0057};
    tbl[10] = '{1, 4, 3, 1'b0, -1, 0};
    tbl[11] = '{1, 4, 4, 1'b1, 0, 'h0100};
    tbl[12] = '{1, 4, 4, 1'b1, 24, 'h0144};
    tbl[13] = '{1, 5, 7, 1'b1, 24, 'h0157};

    reset           = 1'b0;
    bus.pixel_in    = '0;
    bus.pixel_valid = 1'b0;
    bus.out_ready   = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_state("reset");
    reset = 1'b1;

    // Continuous frame, then a back-to-back second frame.
    run_frame(0, W*H);
    run_frame(1, W*H);

    // Reset after pixel (4,6), then the first frame must replay identically.
    run_frame(0, 4*W + 7);
    chk("pre_reset_valid", 32'(bus.window_valid), 32'd1);
    #2 reset = 1'b0;
    #1;
    chk_reset_state("async_reset");
    @(posedge clk);
    #1;
    reset = 1'b1;
    run_frame(0, W*H);

    // Backpressure at the first window of a fresh frame.
    step(16'h0, 1'b0, 1'b1, took);
    consumed = 0;
    for (int i = 0; i < 4*W + 4; i++)
      step(16'((i / W)*16 + (i % W)), 1'b1, 1'b1, took);
    step(16'h0044, 1'b1, 1'b0, took);
    chk("bp_first_valid", 32'(bus.window_valid), 32'd1);
    chk("bp_ready_low", 32'(bus.pixel_ready), 32'd0);
    chk("bp_elem24", 32'(elem(24)), 32'h0044);
    for (int s = 0; s < 3; s++) begin
      step(16'h0045, 1'b1, 1'b0, took);
      chk($sformatf("bp_stall_took%0d", s), 32'(took), 32'd0);
      chk($sformatf("bp_stall_valid%0d", s), 32'(bus.window_valid), 32'd1);
      chk($sformatf("bp_stall_elem24_%0d", s), 32'(elem(24)), 32'h0044);
    end
    step(16'h0045, 1'b1, 1'b1, took);
    chk("bp_release_took", 32'(took), 32'd1);
    chk("bp_release_valid", 32'(bus.window_valid), 32'd1);
    chk("bp_release_elem24", 32'(elem(24)), 32'h0045);
    for (int i = 4*W + 6; i < W*H; i++)
      step(16'((i / W)*16 + (i % W)), 1'b1, 1'b1, took);
    chk("bp_frame_done", 32'(bus.frame_done), 32'd1);
    step(16'h0, 1'b0, 1'b1, took);
    chk("bp_consumed_count", 32'(consumed), 32'd8);
    chk("bp_idle_valid", 32'(bus.window_valid), 32'd0);
    chk("bp_frame_done_pulse", 32'(bus.frame_done), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
